// File: rtl/snax_tcdm_bank_responder.sv
// Single-port TCDM word bank shared by NumPorts requestors: round-robin grant, strobed writes, fixed-latency responses.
// Optional macro SNAX_TCDM_BANK_RSP_REG_EN adds a second response register stage (latency 2).
module snax_tcdm_bank_responder #(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 17,
    parameter int unsigned Depth     = 512
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NumPorts-1:0]             req_valid_i,
    output logic [NumPorts-1:0]             req_ready_o,
    input  logic [NumPorts*AddrWidth-1:0]   req_addr_i,
    input  logic [NumPorts-1:0]             req_write_i,
    input  logic [NumPorts*DataWidth-1:0]   req_data_i,
    input  logic [NumPorts*DataWidth/8-1:0] req_strb_i,
    output logic [NumPorts-1:0]             rsp_valid_o,
    output logic [NumPorts*DataWidth-1:0]   rsp_data_o,
    output logic [31:0]                     conflict_cnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = (StrbWidth > 1) ? $clog2(StrbWidth) : 0;
    localparam int unsigned IdxW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrW      = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0]             ptr_q, ptr_d, win_c;
    logic                        found_c, hs_c, multi_c;
    logic [NumPorts-1:0]         gnt_c;
    logic [IdxW-1:0]             sel_idx_c;
    logic                        sel_write_c;
    logic [DataWidth-1:0]        sel_data_c;
    logic [StrbWidth-1:0]        sel_strb_c;
    logic [DataWidth-1:0]        mem_q [Depth];
    logic [NumPorts-1:0]         rsp_valid_q, rsp_valid_d;
    logic [NumPorts*DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic [31:0]                 conflict_q, conflict_d;
    logic                        unused_addr_c;

    // Byte-offset bits and index bits beyond Depth are intentionally dropped.
    assign unused_addr_c = ^req_addr_i;

    // Round-robin search starting at ptr_q; first valid requestor wins.
    always_comb begin
        logic [PtrW-1:0] cand;
        found_c = 1'b0;
        win_c   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = PtrW'((32'(ptr_q) + i) % NumPorts);
            if (!found_c && req_valid_i[cand]) begin
                found_c = 1'b1;
                win_c   = cand;
            end
        end
        hs_c  = found_c && !reset;
        gnt_c = '0;
        if (hs_c) begin
            gnt_c[win_c] = 1'b1;
        end
    end

    assign req_ready_o = gnt_c;

    // Request fields of the winning port.
    always_comb begin
        sel_idx_c   = '0;
        sel_write_c = 1'b0;
        sel_data_c  = '0;
        sel_strb_c  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (PtrW'(p) == win_c) begin
                sel_idx_c   = req_addr_i[p*AddrWidth + OffW +: IdxW];
                sel_write_c = req_write_i[p];
                sel_data_c  = req_data_i[p*DataWidth +: DataWidth];
                sel_strb_c  = req_strb_i[p*StrbWidth +: StrbWidth];
            end
        end
    end

    // Contention detector: at least two requestors valid this cycle.
    always_comb begin
        logic seen_one;
        seen_one = 1'b0;
        multi_c  = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (req_valid_i[p]) begin
                if (seen_one) begin
                    multi_c = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        conflict_d  = conflict_q;
        if (hs_c) begin
            ptr_d       = (win_c == PtrW'(NumPorts - 1)) ? '0 : win_c + PtrW'(1);
            rsp_valid_d = gnt_c;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (gnt_c[p]) begin
                    rsp_data_d[p*DataWidth +: DataWidth] = sel_write_c ? '0 : mem_q[sel_idx_c];
                end
            end
        end
        if (multi_c && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    // Bank storage is never reset; writes land at the grant edge so the next read sees them.
    always_ff @(posedge clock) begin
        if (hs_c && sel_write_c) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (sel_strb_c[b]) begin
                    mem_q[sel_idx_c][b*8 +: 8] <= sel_data_c[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            conflict_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            conflict_q  <= conflict_d;
        end
    end

`ifdef SNAX_TCDM_BANK_RSP_REG_EN
    logic [NumPorts-1:0]           out_valid_q;
    logic [NumPorts*DataWidth-1:0] out_data_q;

    // Second response stage; valid and data move together.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rsp_valid_q;
            out_data_q  <= rsp_data_q;
        end
    end

    assign rsp_valid_o = out_valid_q;
    assign rsp_data_o  = out_data_q;
`else
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
`endif

    assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_snax_tcdm_bank_responder.sv
// Scoreboard bench for snax_tcdm_bank_responder: directed requests push expected responses, a monitor pops and checks them.
module tb_snax_tcdm_bank_responder;

`ifdef SNAX_TCDM_BANK_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NP = 4;
    localparam int AW = 17;
    localparam int DW = 64;

    typedef struct {
        int          port;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_ready;
    logic [NP*AW-1:0]  addr_bus;
    logic [NP-1:0]     write_bus;
    logic [NP*DW-1:0]  data_bus;
    logic [NP*8-1:0]   strb_bus;
    logic [NP-1:0]     rsp_valid;
    logic [NP*DW-1:0]  rsp_data;
    logic [31:0]       conflict_cnt;

    logic [AW-1:0] p_addr  [NP];
    logic          p_write [NP];
    logic [DW-1:0] p_data  [NP];
    logic [7:0]    p_strb  [NP];

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    snax_tcdm_bank_responder dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (addr_bus),
        .req_write_i   (write_bus),
        .req_data_i    (data_bus),
        .req_strb_i    (strb_bus),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .conflict_cnt_o(conflict_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        addr_bus  = '0;
        write_bus = '0;
        data_bus  = '0;
        strb_bus  = '0;
        for (int p = 0; p < NP; p++) begin
            addr_bus[p*AW +: AW] = p_addr[p];
            write_bus[p]         = p_write[p];
            data_bus[p*DW +: DW] = p_data[p];
            strb_bus[p*8 +: 8]   = p_strb[p];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [7:0] s);
        p_addr[p]  = a;
        p_write[p] = wr;
        p_data[p]  = d;
        p_strb[p]  = s;
    endtask

    // Drive a valid mask for one cycle, check the grant, and queue the expected response.
    task automatic step(input logic [NP-1:0] vmask, input int exp_port,
                        input logic [63:0] exp_rsp, input bit push);
        logic [NP-1:0] exp_rdy;
        req_valid = vmask;
        #1;
        exp_rdy = (exp_port >= 0) ? NP'(1 << exp_port) : '0;
        check("grant", 64'(req_ready), 64'(exp_rdy));
        if (exp_port >= 0 && push) begin
            sb_q.push_back('{port: exp_port, data: exp_rsp, due: cyc + LAT});
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, -1, '0, 1'b0);
    endtask

    // Response monitor: every presented response must match the head of the scoreboard.
    always @(negedge clock) begin
        for (int p = 0; p < NP; p++) begin
            if (rsp_valid[p]) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: port %0d data %h with nothing pending", p, rsp_data[p*DW +: DW]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_port", 64'(p), 64'(e.port));
                    check("rsp_data", rsp_data[p*DW +: DW], e.data);
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, '0, '0, '0);

        // Reset state, with all ports requesting.
        @(negedge clock);
        req_valid = '1;
        #1;
        check("ready_in_reset", 64'(req_ready), 64'h0);
        @(negedge clock);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_rsp_data0", rsp_data[0 +: DW], 64'h0);
        check("reset_conflict", 64'(conflict_cnt), 64'h0);
        req_valid = '0;
        reset = 1'b0;

        // Full write then read-after-write on port 0.
        set_port(0, 1'b1, 17'h40, 64'h1122334455667788, 8'hFF);
        step(4'b0001, 0, 64'h0, 1'b1);
        set_port(0, 1'b0, 17'h40, 64'h0, 8'h00);
        step(4'b0001, 0, 64'h1122334455667788, 1'b1);

        // Strobed write merges into the low bytes only.
        set_port(0, 1'b1, 17'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        step(4'b0001, 0, 64'h0, 1'b1);
        set_port(0, 1'b0, 17'h40, 64'h0, 8'h00);
        step(4'b0001, 0, 64'h11223344AAAAAAAA, 1'b1);

        // Zero-strobe write still responds and leaves memory alone.
        set_port(1, 1'b1, 17'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        step(4'b0010, 1, 64'h0, 1'b1);

        // Address wrap and ignored byte offset.
        set_port(1, 1'b1, 17'h1000, 64'h000000000000DEAD, 8'hFF);
        step(4'b0010, 1, 64'h0, 1'b1);
        set_port(1, 1'b0, 17'h0, 64'h0, 8'h00);
        step(4'b0010, 1, 64'h000000000000DEAD, 1'b1);
        set_port(0, 1'b0, 17'h43, 64'h0, 8'h00);
        step(4'b0001, 0, 64'h11223344AAAAAAAA, 1'b1);
        set_port(3, 1'b1, 17'h80, 64'h0123456789ABCDEF, 8'hFF);
        step(4'b1000, 3, 64'h0, 1'b1);
        idle(LAT + 1);

        // Round-robin with all ports reading, starting from a fresh pointer.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("conflict_after_reset", 64'(conflict_cnt), 64'h0);
        set_port(0, 1'b0, 17'h40, 64'h0, 8'h00);
        set_port(1, 1'b0, 17'h0,  64'h0, 8'h00);
        set_port(2, 1'b0, 17'h80, 64'h0, 8'h00);
        set_port(3, 1'b0, 17'h43, 64'h0, 8'h00);
        step(4'b1111, 0, 64'h11223344AAAAAAAA, 1'b1);
        step(4'b1111, 1, 64'h000000000000DEAD, 1'b1);
        step(4'b1111, 2, 64'h0123456789ABCDEF, 1'b1);
        step(4'b1111, 3, 64'h11223344AAAAAAAA, 1'b1);
        check("conflict_4", 64'(conflict_cnt), 64'd4);
        step(4'b1111, 0, 64'h11223344AAAAAAAA, 1'b1);
        check("conflict_5", 64'(conflict_cnt), 64'd5);
        step(4'b0100, 2, 64'h0123456789ABCDEF, 1'b1);
        check("conflict_single", 64'(conflict_cnt), 64'd5);
        idle(LAT + 1);

        // Reset in the cycle after a read grant drops whatever is still in flight.
        step(4'b0010, 1, 64'h000000000000DEAD, LAT == 1);
        reset = 1'b1;
        req_valid = '1;
        #1;
        check("ready_mid_reset", 64'(req_ready), 64'h0);
        @(negedge clock);
        check("mid_reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("mid_reset_conflict", 64'(conflict_cnt), 64'h0);
        reset = 1'b0;
        step(4'b1111, 0, 64'h11223344AAAAAAAA, 1'b1);
        idle(LAT + 2);

        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snax_tcdm_bank_responder.md
Name: snax_tcdm_bank_responder

Overview:
- Responder end of the TCDM request/response interface driven by generated streamers: NumPorts requestor ports share one single-port SRAM word bank.
- Arbitrates requestors round-robin, performs byte-strobed writes and fixed-latency reads, and returns responses on the granted port.
- Used as the memory-side model/endpoint for streamer-wrapper integration benches, and as a standalone scratch bank.

Parameters:
- NumPorts, 4, number of requestor ports; must be 1..32.
- DataWidth, 64, TCDM data width in bits; must be a multiple of 8.
- AddrWidth, 17, byte address width.
- Depth, 512, bank words; must be a power of 2 and no greater than 2^(AddrWidth-log2(DataWidth/8)).

Ports:
- clock  in  1  accelerator-domain clock
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  NumPorts  per-port q_valid
- req_ready_o  out  NumPorts  per-port q_ready (grant)
- req_addr_i  in  NumPorts*AddrWidth  byte address per port
- req_write_i  in  NumPorts  1 = write, 0 = read
- req_data_i  in  NumPorts*DataWidth  write data
- req_strb_i  in  NumPorts*DataWidth/8  byte enables
- rsp_valid_o  out  NumPorts  per-port p_valid
- rsp_data_o  out  NumPorts*DataWidth  read data per port
- conflict_cnt_o  out  32  saturating count of contention cycles

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset:
  - rsp_valid_o = 0, rsp_data_o = 0, conflict_cnt_o = 0.
  - RR pointer = 0.
  - Memory contents are not cleared.
  - req_ready_o is combinational; it is all-zero while reset = 1.
- Arbitration:
  - Combinational. Search from port ptr upward with wrap-around; the first port with req_valid_i = 1 wins.
  - req_ready_o is one-hot (winner only), or zero if no request is valid.
  - A handshake occurs when valid & ready.
  - After a handshake, ptr <= (winner + 1) mod NumPorts. With no handshake, ptr holds.
  - A requestor may drop valid before it is granted; no request is buffered.
- Address:
  - word index = addr[AddrWidth-1 : log2(DataWidth/8)] mod Depth.
  - Low byte-offset bits are ignored.
  - Out-of-range addresses wrap; they are not errors.
- Write (granted, write = 1):
  - On the same clock edge, byte i of mem[index] <= data byte i for each strb[i] = 1.
  - strb = 0 leaves memory unchanged but still produces a response.
- Read (granted, write = 0): mem[index] is sampled at the grant edge.
- Response:
  - Latency 1. In the cycle after a handshake on port k, rsp_valid_o[k] = 1 for exactly one cycle.
  - rsp_data_o[k] = read word for reads, or all-zero for writes. All other rsp_valid_o bits are 0.
  - No response backpressure exists; the requestor must accept it.
  - rsp_data_o[k] holds its last value when rsp_valid_o[k] = 0.
- Hazards:
  - One access per cycle, so there are no same-cycle conflicts.
  - A read granted in the cycle after a write to the same word returns the new data, with strobe-merged bytes.
- Throughput: one handshake per cycle, with back-to-back grants allowed to the same or different ports.
- conflict_cnt_o: increments by 1 in each cycle where popcount(req_valid_i) >= 2; saturates at 0xFFFF_FFFF.
- Reset mid-operation: an in-flight response is dropped (rsp_valid_o = 0 the next cycle) and ptr returns to 0.

Optional Feature:
- Macro: SNAX_TCDM_BANK_RSP_REG_EN.
- Defined: an extra output register stage is added. Response latency becomes 2 cycles, with rsp_valid_o/rsp_data_o pipelined together. Read-after-write forwarding is unchanged, since memory is updated at the grant edge. Reset clears both stages.
- Undefined: latency is 1 as above.

Test Plan:
- Single write then read, port 0:
  - Write 0x1122334455667788 at addr 0x40 with strb 0xFF, then read 0x40.
  - Required: rsp_valid_o[0] one cycle after each grant; write response data 0; read response data 0x1122334455667788.
- Strobed write: write 0xAAAAAAAAAAAAAAAA at 0x40 with strb 0x0F, then read → 0x11223344AAAAAAAA.
- Round-robin:
  - Ports 0..3 hold valid continuously with reads.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles; conflict_cnt_o increments each cycle (4 after 4 cycles).
  - Port 2 alone valid → granted immediately regardless of ptr.
- Address wrap: Depth = 512, DataWidth = 64. Write 0xDEAD at 0x1000 (index 512 → 0), then read 0x0 → 0xDEAD; addr 0x43 reads the same word as 0x40.
- Reset mid-flight: assert reset in the cycle after a read grant.
  - Required: rsp_valid_o = 0 the next cycle, conflict_cnt_o = 0, and the first grant after reset goes to port 0 when all ports are valid.
- With SNAX_TCDM_BANK_RSP_REG_EN: repeat the first scenario; responses arrive exactly 2 cycles after each grant.
